// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: flit format and switch buffer sizing.
package chiplet_types_pkg;

  localparam int unsigned FLIT_DEST_W    = 4;
  localparam int unsigned FLIT_PAYLOAD_W = 8;

  typedef struct packed {
    logic [FLIT_DEST_W-1:0]    dest;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;

  // Input buffer depth; the upstream credit counter is initialised from this.
  localparam int unsigned SWITCH_BUF_DEPTH = 8;

endpackage

// File: rtl/switch_flit_fifo.sv
// Generic DEPTH x flit_t circular buffer with zero-latency head view.
module switch_flit_fifo
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned DEPTH = SWITCH_BUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  flit_t            wdata,
  output flit_t            rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  flit_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointers/occupancy; a same-cycle pop frees the slot for a push when full.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/switch_bid_buffer.sv
// Requester side of switch arbitration: buffers flits, bids, pops on grant, returns credits.
module switch_bid_buffer
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned DEPTH   = SWITCH_BUF_DEPTH,
  parameter  int unsigned PORT_ID = 0,
  parameter  int unsigned NPORTS  = 4,
  localparam int unsigned SEL_W   = $clog2(NPORTS),
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  input  flit_t            in_flit,
  input  logic             arb_valid,
  input  logic [SEL_W-1:0] arb_select,
  input  logic             out_ready,
  output logic             bid,
  output flit_t            rdata,
  output logic             credit_return,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err
);

  logic grant;
  logic fifo_full, fifo_empty;
  logic credit_return_q;
  logic overflow_err_q, overflow_err_d;

  switch_flit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (in_valid),
    .pop   (grant),
    .wdata (in_flit),
    .rdata (rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Grant decode and sticky drop detection (push into a full buffer with no pop).
  always_comb begin
    grant          = arb_valid && (arb_select == SEL_W'(PORT_ID)) && out_ready && !fifo_empty;
    overflow_err_d = overflow_err_q || (in_valid && fifo_full && !grant);
  end

  // Credit pulse one cycle after each pop; overflow flag held until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      credit_return_q <= 1'b0;
      overflow_err_q  <= 1'b0;
    end else begin
      credit_return_q <= grant;
      overflow_err_q  <= overflow_err_d;
    end
  end

  assign bid           = !fifo_empty;
  assign credit_return = credit_return_q;
  assign overflow_err  = overflow_err_q;

endmodule
